// File: rtl/greedy_snake_body_ctrl.sv
// greedy_snake_body_ctrl
// Owns the snake body as a ring buffer of grid coordinates and consumes the
// key controller's step interface. Each accepted step advances the head and
// checks it against the walls, the food and every body segment that will
// still be occupied. The body then either grows, moves, or the game ends.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   en, forward, mode step request, direction (00 x+1, 01 x-1, 10 y+1,
//                     11 y-1), mode (0 = re-initialise, otherwise update)
//   food_x/y/valid    current food cell
//   busy              FSM is not idle
//   step_done, ate    one-cycle pulses at the end of a step
//   game_over         sticky collision flag
//   head_x/y, len     current head cell and segment count
//   rd_idx -> rd_x/y, rd_valid   registered segment read port (0 = head)
module greedy_snake_body_ctrl #(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int X_W      = 6,
    parameter int Y_W      = 5,
    parameter int MAX_LEN  = 64,
    parameter int LEN_W    = 7,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 4,
    parameter int INIT_Y   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       forward,
    input  logic [3:0]       mode,
    input  logic [X_W-1:0]   food_x,
    input  logic [Y_W-1:0]   food_y,
    input  logic             food_valid,
    output logic             busy,
    output logic             step_done,
    output logic             ate,
    output logic             game_over,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] len,
    input  logic [LEN_W-1:0] rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y,
    output logic             rd_valid
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam logic [X_W:0] X_ONE    = (X_W+1)'(1);
    localparam logic [Y_W:0] Y_ONE    = (Y_W+1)'(1);
    localparam logic [X_W:0] X_LIMIT  = (X_W+1)'(GRID_W);
    localparam logic [Y_W:0] Y_LIMIT  = (Y_W+1)'(GRID_H);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_NEXT,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t state_reg, state_next;

    logic [X_W-1:0]   ring_x [MAX_LEN];
    logic [Y_W-1:0]   ring_y [MAX_LEN];

    logic [PTR_W-1:0] head_ptr_reg;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] init_cnt_reg;
    logic [LEN_W-1:0] chk_idx_reg;
    logic [LEN_W-1:0] n_check_reg;
    logic [1:0]       dir_reg;
    logic [X_W-1:0]   head_x_reg, nx_reg;
    logic [Y_W-1:0]   head_y_reg, ny_reg;
    logic             eat_reg, grow_reg;
    logic             game_over_reg;
    logic             step_done_reg;

    // Candidate head, one bit wider so that 0-1 wraps to a value >= limit.
    logic [X_W:0]     nx_wide;
    logic [Y_W:0]     ny_wide;
    logic             wall_hit;
    logic             food_hit;
    logic             grow_c;
    logic [LEN_W-1:0] n_check_c;

    logic [PTR_W-1:0] chk_addr;
    logic             seg_hit;
    logic [PTR_W-1:0] init_addr;
    logic [X_W-1:0]   init_x;
    logic             init_last;
    logic [PTR_W-1:0] wr_ptr;

    always_comb begin
        nx_wide = {1'b0, head_x_reg};
        ny_wide = {1'b0, head_y_reg};
        case (dir_reg)
            2'b00: nx_wide = {1'b0, head_x_reg} + X_ONE;
            2'b01: nx_wide = {1'b0, head_x_reg} - X_ONE;
            2'b10: ny_wide = {1'b0, head_y_reg} + Y_ONE;
            default: ny_wide = {1'b0, head_y_reg} - Y_ONE;
        endcase
    end

    assign wall_hit  = (nx_wide >= X_LIMIT) || (ny_wide >= Y_LIMIT);
    assign food_hit  = food_valid && (nx_wide[X_W-1:0] == food_x)
                                  && (ny_wide[Y_W-1:0] == food_y);
    assign grow_c    = food_hit && (len_reg < LEN_W'(MAX_LEN));
    // When not growing the tail leaves its cell this step, so it is not a hazard.
    assign n_check_c = grow_c ? len_reg : (len_reg - LEN_ONE);

    assign chk_addr  = head_ptr_reg - chk_idx_reg[PTR_W-1:0];
    assign seg_hit   = (ring_x[chk_addr] == nx_reg) && (ring_y[chk_addr] == ny_reg);

    assign init_addr = PTR_W'(INIT_LEN - 1) - init_cnt_reg[PTR_W-1:0];
    assign init_x    = X_W'(INIT_X) - X_W'(init_cnt_reg);
    assign init_last = (init_cnt_reg == LEN_W'(INIT_LEN - 1));
    assign wr_ptr    = head_ptr_reg + PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_INIT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT: begin
                if (init_last) state_next = S_IDLE;
            end
            S_IDLE: begin
                if (mode == 4'd0) begin
                    state_next = S_INIT;
                end else if (en && !game_over_reg) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (wall_hit) begin
                    state_next = S_IDLE;
                end else if (n_check_c == '0) begin
                    state_next = S_COMMIT;
                end else begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (seg_hit) begin
                    state_next = S_IDLE;
                end else if (chk_idx_reg == n_check_reg - LEN_ONE) begin
                    state_next = S_COMMIT;
                end
            end
            S_COMMIT: state_next = S_IDLE;
            default:  state_next = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr_reg  <= PTR_W'(INIT_LEN - 1);
            len_reg       <= LEN_W'(INIT_LEN);
            head_x_reg    <= X_W'(INIT_X);
            head_y_reg    <= Y_W'(INIT_Y);
            game_over_reg <= 1'b0;
            step_done_reg <= 1'b0;
            init_cnt_reg  <= '0;
            chk_idx_reg   <= '0;
            n_check_reg   <= '0;
            dir_reg       <= 2'b00;
            nx_reg        <= '0;
            ny_reg        <= '0;
            eat_reg       <= 1'b0;
            grow_reg      <= 1'b0;
        end else begin
            step_done_reg <= 1'b0;
            case (state_reg)
                S_INIT: begin
                    init_cnt_reg  <= init_cnt_reg + LEN_ONE;
                    head_ptr_reg  <= PTR_W'(INIT_LEN - 1);
                    len_reg       <= LEN_W'(INIT_LEN);
                    head_x_reg    <= X_W'(INIT_X);
                    head_y_reg    <= Y_W'(INIT_Y);
                    game_over_reg <= 1'b0;
                end
                S_IDLE: begin
                    init_cnt_reg <= '0;
                    if (mode != 4'd0 && en && !game_over_reg) begin
                        dir_reg <= forward;
                    end
                end
                S_NEXT: begin
                    chk_idx_reg <= '0;
                    if (wall_hit) begin
                        game_over_reg <= 1'b1;
                        step_done_reg <= 1'b1;
                    end else begin
                        nx_reg      <= nx_wide[X_W-1:0];
                        ny_reg      <= ny_wide[Y_W-1:0];
                        eat_reg     <= food_hit;
                        grow_reg    <= grow_c;
                        n_check_reg <= n_check_c;
                    end
                end
                S_CHECK: begin
                    if (seg_hit) begin
                        game_over_reg <= 1'b1;
                        step_done_reg <= 1'b1;
                    end else begin
                        chk_idx_reg <= chk_idx_reg + LEN_ONE;
                    end
                end
                S_COMMIT: begin
                    head_ptr_reg <= wr_ptr;
                    head_x_reg   <= nx_reg;
                    head_y_reg   <= ny_reg;
                    if (grow_reg) len_reg <= len_reg + LEN_ONE;
                end
                default: ;
            endcase
        end
    end

    // Ring storage is not reset; INIT rewrites every live segment.
    // Writes are suppressed while rst is high so an aborted step leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == S_INIT) begin
                ring_x[init_addr] <= init_x;
                ring_y[init_addr] <= Y_W'(INIT_Y);
            end else if (state_reg == S_COMMIT) begin
                ring_x[wr_ptr] <= nx_reg;
                ring_y[wr_ptr] <= ny_reg;
            end
        end
    end

    // Renderer read port: sees the pre-commit body until the COMMIT edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end else if (rd_idx < len_reg) begin
            rd_x     <= ring_x[head_ptr_reg - rd_idx[PTR_W-1:0]];
            rd_y     <= ring_y[head_ptr_reg - rd_idx[PTR_W-1:0]];
            rd_valid <= 1'b1;
        end else begin
            rd_x     <= '0;
            rd_y     <= '0;
            rd_valid <= 1'b0;
        end
    end

    // Commit-time pulses come straight from the COMMIT state; collision
    // pulses are registered as the FSM drops back to IDLE.
    assign busy      = (state_reg != S_IDLE);
    assign step_done = step_done_reg || (state_reg == S_COMMIT);
    assign ate       = (state_reg == S_COMMIT) && eat_reg;
    assign game_over = game_over_reg;
    assign head_x    = head_x_reg;
    assign head_y    = head_y_reg;
    assign len       = len_reg;

endmodule

// File: tb/tb_greedy_snake_body_ctrl.sv
// Testbench for greedy_snake_body_ctrl.
// The snake is modelled as a queue of cells (index 0 = head). Each issued step
// pushes its expected outcome (completion cycle, ate, game_over, head, length)
// into a scoreboard queue; a monitor pops on every step_done. Segment reads
// are scoreboarded the same way against the modelled body.
module tb_greedy_snake_body_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] forward = 2'b00;
    logic [3:0] mode = 4'd1;
    logic [5:0] food_x = '0;
    logic [4:0] food_y = '0;
    logic       food_valid = 1'b0;
    logic       busy, step_done, ate, game_over;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [6:0] len;
    logic [6:0] rd_idx = '0;
    logic [5:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_valid;

    greedy_snake_body_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .forward(forward), .mode(mode),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .step_done(step_done), .ate(ate), .game_over(game_over),
        .head_x(head_x), .head_y(head_y), .len(len),
        .rd_idx(rd_idx), .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        int ate;
        int go;
        int hx;
        int hy;
        int len;
    } step_exp_t;

    typedef struct {
        int v;
        int x;
        int y;
    } rd_exp_t;

    step_exp_t step_q[$];
    rd_exp_t   rd_q[$];

    // Reference body: bx[i], by[i] is segment i.
    int bx[$];
    int by[$];
    bit m_go;

    logic rd_strobe = 1'b0;
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= rd_strobe;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        bx.delete();
        by.delete();
        for (int i = 0; i < 3; i++) begin
            bx.push_back(4 - i);
            by.push_back(12);
        end
        m_go = 1'b0;
    endfunction

    function automatic void model_step(input int d, input bit fv, input int fx, input int fy,
                                       output int lat, output bit a);
        int nx, ny, n;
        bit eat, grow;
        nx = bx[0] + ((d == 0) ? 1 : 0) - ((d == 1) ? 1 : 0);
        ny = by[0] + ((d == 2) ? 1 : 0) - ((d == 3) ? 1 : 0);
        a = 1'b0;
        if (nx < 0 || nx >= 32 || ny < 0 || ny >= 24) begin
            m_go = 1'b1;
            lat = 2;
            return;
        end
        eat  = fv && nx == fx && ny == fy;
        grow = eat && bx.size() < 64;
        n    = grow ? bx.size() : bx.size() - 1;
        for (int k = 0; k < n; k++) begin
            if (bx[k] == nx && by[k] == ny) begin
                m_go = 1'b1;
                lat = 3 + k;
                return;
            end
        end
        bx.push_front(nx);
        by.push_front(ny);
        if (!grow) begin
            void'(bx.pop_back());
            void'(by.pop_back());
        end
        lat = n + 2;
        a = eat;
    endfunction

    // Step monitor
    initial begin
        step_exp_t e;
        forever begin
            @(negedge clk);
            if (step_done === 1'b1) begin
                if (step_q.size() == 0) begin
                    chk("unexpected_step_done", 1, 0);
                end else begin
                    e = step_q.pop_front();
                    chk("step_latency", cyc, e.done_cyc);
                    chk("ate", int'(ate), e.ate);
                    @(negedge clk);
                    chk("game_over", int'(game_over), e.go);
                    chk("head_x", int'(head_x), e.hx);
                    chk("head_y", int'(head_y), e.hy);
                    chk("len", int'(len), e.len);
                    $display("step: cycle %0d ate=%0d game_over=%0d head=(%0d,%0d) len=%0d",
                             cyc, e.ate, e.go, e.hx, e.hy, e.len);
                end
            end
        end
    end

    // Read-port monitor
    initial begin
        rd_exp_t r;
        forever begin
            @(negedge clk);
            if (rd_seen === 1'b1) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_read", 1, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rd_valid", int'(rd_valid), r.v);
                    chk("rd_x", int'(rd_x), r.x);
                    chk("rd_y", int'(rd_y), r.y);
                    $display("read: valid=%0d seg=(%0d,%0d)", r.v, r.x, r.y);
                end
            end
        end
    end

    task automatic do_read(input int idx);
        rd_exp_t r;
        @(negedge clk);
        rd_idx = idx[6:0];
        if (idx < bx.size()) begin
            r.v = 1; r.x = bx[idx]; r.y = by[idx];
        end else begin
            r.v = 0; r.x = 0; r.y = 0;
        end
        rd_q.push_back(r);
        rd_strobe = 1'b1;
        @(negedge clk);
        rd_strobe = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < bx.size(); i++) do_read(i);
        do_read(bx.size());
        do_read($urandom_range(bx.size(), 127));
        repeat (2) @(negedge clk);
    endtask

    task automatic do_step(input int d, input bit fv, input int fx, input int fy);
        int lat;
        bit a;
        bit accepted;
        step_exp_t e;
        int n;
        @(negedge clk);
        food_valid = fv;
        food_x = fx[5:0];
        food_y = fy[4:0];
        forward = d[1:0];
        en = 1'b1;
        accepted = !m_go;
        if (accepted) begin
            model_step(d, fv, fx, fy, lat, a);
            e.done_cyc = cyc + lat;
            e.ate = int'(a);
            e.go = int'(m_go);
            e.hx = bx[0];
            e.hy = by[0];
            e.len = bx.size();
            step_q.push_back(e);
        end
        @(negedge clk);
        en = 1'b0;
        n = 0;
        while (step_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (step_q.size() != 0) begin
            chk("step_timeout", 1, 0);
            step_q.delete();
        end
        repeat (accepted ? 3 : 12) @(negedge clk);
    endtask

    task automatic apply_reset(input bit abort_step);
        int n;
        if (abort_step) begin
            // Start a step, then hit reset while it is in its collision scan.
            @(negedge clk);
            forward = 2'b00;
            food_valid = 1'b0;
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            @(negedge clk);
        end
        rst = 1'b1;
        en = 1'b0;
        mode = 4'd1;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 1);
        chk("rst_step_done", int'(step_done), 0);
        chk("rst_ate", int'(ate), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_head_x", int'(head_x), 4);
        chk("rst_head_y", int'(head_y), 12);
        chk("rst_len", int'(len), 3);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_x", int'(rd_x), 0);
        chk("rst_rd_y", int'(rd_y), 0);
        rst = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("init_busy_cycles", n, 3);
        model_reset();
    endtask

    task automatic do_reinit();
        int n;
        @(negedge clk);
        en = 1'b0;
        mode = 4'd0;
        @(negedge clk);
        mode = 4'($urandom_range(1, 15));
        forward = 2'($urandom_range(0, 3));
        en = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        en = 1'b0;
        chk("reinit_busy_cycles", n, 3);
        model_reset();
        chk("reinit_game_over", int'(game_over), 0);
        chk("reinit_head_x", int'(head_x), 4);
        chk("reinit_head_y", int'(head_y), 12);
        chk("reinit_len", int'(len), 3);
        read_all();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d, nx, ny, fx, fy;
        bit fv;

        // Reset and initial body
        apply_reset(1'b0);
        read_all();

        // Plain move right, then eat food directly ahead
        do_step(0, 1'b0, 0, 0);
        read_all();
        do_step(0, 1'b1, 6, 12);
        read_all();

        // Reset during a step: nothing of it may survive
        apply_reset(1'b1);
        read_all();

        // Walk to the right wall, then run into it
        for (int i = 0; i < 27; i++) do_step(0, 1'b0, 0, 0);
        read_all();
        do_step(0, 1'b0, 0, 0);
        chk("wall_game_over", int'(game_over), 1);
        chk("wall_head_x", int'(head_x), 31);
        // Requests are dropped while the game is over
        do_step(2, 1'b0, 0, 0);
        chk("ignored_head_y", int'(head_y), 12);

        // Re-initialise from game over, en held while busy
        do_reinit();

        // Reverse into segment 1 straight after reset
        apply_reset(1'b0);
        do_step(1, 1'b0, 0, 0);
        chk("reverse_len", int'(len), 3);
        do_reinit();

        // Randomised play
        for (int s = 0; s < 150; s++) begin
            if (m_go) do_reinit();
            d  = $urandom_range(0, 3);
            nx = bx[0] + ((d == 0) ? 1 : 0) - ((d == 1) ? 1 : 0);
            ny = by[0] + ((d == 2) ? 1 : 0) - ((d == 3) ? 1 : 0);
            if ($urandom_range(0, 2) == 0 && nx >= 0 && nx < 32 && ny >= 0 && ny < 24) begin
                fv = 1'b1; fx = nx; fy = ny;
            end else begin
                fv = 1'($urandom_range(0, 1));
                fx = $urandom_range(0, 31);
                fy = $urandom_range(0, 23);
            end
            do_step(d, fv, fx, fy);
            if (s % 5 == 0) read_all();
        end
        read_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/greedy_snake_body_ctrl.md
Name: greedy_snake_body_ctrl

Overview:
Consumer of the snake key controller's step interface (en, forward, mode). Owns the snake body as a ring buffer of grid coordinates. On each step pulse it advances the head, checks for wall, self and food hits, and grows or moves the body. It also exposes a segment read port for the BSRAM/video renderer.

Parameters:
GRID_W, 32, grid columns; legal x is 0..GRID_W-1
GRID_H, 24, grid rows; legal y is 0..GRID_H-1
X_W, 6, x coordinate width
Y_W, 5, y coordinate width
MAX_LEN, 64, ring buffer depth (maximum snake length, power of 2)
LEN_W, 7, length/index width, equal to clog2(MAX_LEN+1)
INIT_LEN, 3, segment count after (re)initialisation
INIT_X, 4, initial head x
INIT_Y, 12, initial head y

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  one-cycle step request
forward  in  2  direction: 00 x+1, 01 x-1, 10 y+1, 11 y-1
mode  in  4  0 = reset snake, 1 = update position; other values treated as 1
food_x  in  X_W  food column
food_y  in  Y_W  food row
food_valid  in  1  food position meaningful
busy  out  1  FSM not in IDLE
step_done  out  1  one-cycle pulse at the end of every accepted step
ate  out  1  one-cycle pulse, coincident with step_done, when food was eaten
game_over  out  1  sticky collision flag
head_x  out  X_W  current head column
head_y  out  Y_W  current head row
len  out  LEN_W  current segment count
rd_idx  in  LEN_W  segment index to read; 0 = head
rd_x  out  X_W  segment column, 1-cycle latency
rd_y  out  Y_W  segment row, 1-cycle latency
rd_valid  out  1  rd_idx was less than len when sampled

Behaviour:
- Segment i is stored at ring[(head_ptr - i) mod MAX_LEN].
- Reset values: busy=1, step_done=0, ate=0, game_over=0, head_x=INIT_X, head_y=INIT_Y, len=INIT_LEN, rd_x=0, rd_y=0, rd_valid=0. After reset the FSM is in INIT. Ring contents are not reset.
- Reset mid-operation aborts any step immediately. No partial commit survives.
- INIT state:
  - Writes segment i = (INIT_X - i, INIT_Y) for i = 0..INIT_LEN-1, one segment per clock.
  - Sets head_ptr = INIT_LEN-1, len = INIT_LEN, game_over = 0.
  - Moves to IDLE. busy stays high for INIT_LEN clocks.
- IDLE state:
  - mode==0: go to INIT, which re-initialises the snake and clears game_over. Priority over en.
  - Otherwise, en=1 and game_over=0: latch forward and go to NEXT.
  - en is ignored while busy or while game_over=1. It is dropped, not queued.
- NEXT state (1 clock):
  - nx/ny = head ± 1, computed in X_W+1 / Y_W+1 bits so x-1 at 0 is detected as underflow.
  - Out of range (nx<0, nx>=GRID_W, ny<0, ny>=GRID_H): set game_over=1, pulse step_done, return to IDLE. Head, len and ring are unchanged.
  - Otherwise: eat = food_valid && (nx,ny)==(food_x,food_y); grow = eat && len<MAX_LEN; go to CHECK.
- CHECK state:
  - Compare (nx,ny) against one segment per clock, idx 0..N-1.
  - N = len if grow, else len-1. The tail vacates the cell when not growing.
  - Any match: set game_over=1, pulse step_done, return to IDLE, no commit.
  - A reversed direction therefore hits segment 1 and ends the game.
- COMMIT state (1 clock):
  - head_ptr+1 mod MAX_LEN; ring[head_ptr] = (nx,ny); head_x/head_y updated.
  - len+1 if grow.
  - Pulse step_done, and ate if eat. ate also pulses at len==MAX_LEN with no growth; the tail then moves.
- Latency: step_done is high N+2 clocks after the edge that sampled en (2 clocks for a wall hit).
- Read port:
  - Registered; independent of the FSM.
  - Returns pre-commit data until the COMMIT edge.
  - rd_idx>=len gives rd_valid=0 and rd_x=rd_y=0.
- head_ptr wraps modulo MAX_LEN with no special handling.

Test Plan:
1. Reset release → busy high 3 clocks then 0; rd_idx 0,1,2 → (4,12),(3,12),(2,12) with rd_valid=1; rd_idx 3 → rd_valid=0.
2. en, forward=00, no food → step_done 4 clocks later; head (5,12); len 3; segments (5,12),(4,12),(3,12); ate=0.
3. Then food (6,12) valid, en forward=00 → step_done 5 clocks later with ate=1; len 4; segments (6,12),(5,12),(4,12),(3,12).
4. Drive head to x=31, en forward=00 → game_over=1 and step_done 2 clocks later; head stays (31,12); further en ignored (no step_done).
5. From reset, en forward=01 (reverse) → next head (3,12) matches segment 1 → game_over=1; len stays 3.
6. Set game_over, then mode=0 for 1 clock → INIT, busy 3 clocks, game_over=0, head (4,12); en asserted while busy → no step_done.
